// File: rtl/seg_display_arbiter_if.sv
// Request/value inputs and display outputs shared between the debug sources and the display arbiter.
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [11:0] value0;
  logic [11:0] value1;
  logic [11:0] value2;
  logic        freeze;
  logic [2:0]  grant;
  logic [2:0]  ack;
  logic [3:0]  digit_l;
  logic [3:0]  digit_m;
  logic [3:0]  digit_r;

  // Requester side: drives requests and values, observes grant and digits.
  modport master (
    output req, value0, value1, value2, freeze,
    input  grant, ack, digit_l, digit_m, digit_r
  );

  // Arbiter side.
  modport slave (
    input  req, value0, value1, value2, freeze,
    output grant, ack, digit_l, digit_m, digit_r
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 3-digit seven-segment display with programmable dwell and grant ack.
module seg_display_arbiter #(
  parameter int unsigned DWELL      = 2**22,
  parameter logic [11:0] IDLE_VALUE = 12'h000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seg_display_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DWELL);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       ack_q, ack_d;
  logic [11:0]      digits_q, digits_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             expire;

  // Index following i in the cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Value of requester idx.
  function automatic logic [11:0] value_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return bus.value0;
      2'd1:    return bus.value1;
      default: return bus.value2;
    endcase
  endfunction

  // Round-robin search starting after last_q and ending on last_q itself.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int i = 0; i < 3; i++) begin
      cand = rr_next(cand);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic; freeze holds everything except the ack pulse.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ack_d    = 3'b000;
    digits_d = digits_q;
    expire   = (cnt_q == '0) || !bus.req[last_q];

    if (!bus.freeze) begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_d  = HOLD;
            last_d   = win_idx;
            cnt_d    = CNT_W'(DWELL - 1);
            grant_d  = 3'b001 << win_idx;
            ack_d    = 3'b001 << win_idx;
            digits_d = value_of(win_idx);
          end
        end
        HOLD: begin
          if (bus.req[last_q]) begin
            digits_d = value_of(last_q);
          end
          if (!expire) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!win_found) begin
            state_d  = IDLE;
            grant_d  = 3'b000;
            digits_d = IDLE_VALUE;
          end else if (win_idx != last_q) begin
            last_d   = win_idx;
            cnt_d    = CNT_W'(DWELL - 1);
            grant_d  = 3'b001 << win_idx;
            ack_d    = 3'b001 << win_idx;
            digits_d = value_of(win_idx);
          end else begin
            cnt_d = CNT_W'(DWELL - 1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 2'd2;
      cnt_q    <= '0;
      grant_q  <= 3'b000;
      ack_q    <= 3'b000;
      digits_q <= IDLE_VALUE;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      digits_q <= digits_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.ack     = ack_q;
  assign bus.digit_l = digits_q[11:8];
  assign bus.digit_m = digits_q[7:4];
  assign bus.digit_r = digits_q[3:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with DWELL=4, IDLE_VALUE=0.
module tb_seg_display_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  seg_display_arbiter_if bus();

  seg_display_arbiter #(
    .DWELL      (4),
    .IDLE_VALUE (12'h000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] digits();
    return {bus.digit_l, bus.digit_m, bus.digit_r};
  endfunction

  // Asynchronous reset between edges, observed before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    check({tag, "_grant"}, 32'(bus.grant), 32'h0);
    check({tag, "_ack"}, 32'(bus.ack), 32'h0);
    check({tag, "_digits"}, 32'(digits()), 32'h000);
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
  endtask

  logic [2:0]  order [3];
  logic [11:0] vals [3];

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    bus.req     = 3'b000;
    bus.value0  = 12'h000;
    bus.value1  = 12'h000;
    bus.value2  = 12'h000;
    bus.freeze  = 1'b0;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    vals[0]  = 12'hABC; vals[1] = 12'h123; vals[2] = 12'h456;

    repeat (3) tick();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_digits", 32'(digits()), 32'h000);
    release_reset();
    tick();

    // Tie after reset: 0, 1, 2 each hold four cycles with one ack.
    bus.value0 = 12'hABC; bus.value1 = 12'h123; bus.value2 = 12'h456;
    bus.req = 3'b111;
    for (int o = 0; o < 3; o++) begin
      tick();
      check("tie_grant", 32'(bus.grant), 32'(order[o]));
      check("tie_ack", 32'(bus.ack), 32'(order[o]));
      check("tie_digits", 32'(digits()), 32'(vals[o]));
      for (int c = 0; c < 3; c++) begin
        tick();
        check("tie_hold_grant", 32'(bus.grant), 32'(order[o]));
        check("tie_hold_ack", 32'(bus.ack), 32'h0);
      end
    end
    tick();
    check("tie_wrap_grant", 32'(bus.grant), 32'h1);
    check("tie_wrap_ack", 32'(bus.ack), 32'h1);

    // Reset in the middle of a hold, then a fresh request.
    async_reset("midhold");
    bus.req = 3'b001;
    release_reset();
    tick();
    check("postrst_ack", 32'(bus.ack), 32'h1);
    check("postrst_grant", 32'(bus.grant), 32'h1);

    // Single requester keeps the display with one ack and live values.
    async_reset("single_rst");
    bus.req = 3'b010;
    bus.value1 = 12'h111;
    release_reset();
    tick();
    check("single_grant0", 32'(bus.grant), 32'h2);
    check("single_ack0", 32'(bus.ack), 32'h2);
    check("single_digits0", 32'(digits()), 32'h111);
    for (int i = 0; i < 20; i++) begin
      if (i == 6) bus.value1 = 12'h222;
      tick();
      check("single_grant", 32'(bus.grant), 32'h2);
      check("single_ack", 32'(bus.ack), 32'h0);
      check("single_digits", 32'(digits()), (i < 6) ? 32'h111 : 32'h222);
    end

    // Early release of owner 0 with requester 2 waiting.
    async_reset("early_rst");
    bus.req = 3'b101;
    bus.value0 = 12'hABC;
    bus.value2 = 12'h456;
    release_reset();
    tick();
    check("early_grant0", 32'(bus.grant), 32'h1);
    check("early_digits0", 32'(digits()), 32'hABC);
    tick();
    bus.req = 3'b100;
    tick();
    check("early_grant", 32'(bus.grant), 32'h4);
    check("early_ack", 32'(bus.ack), 32'h4);
    check("early_digits", 32'(digits()), 32'h456);

    // Freeze for five cycles inside owner 1's dwell delays the hand-over.
    async_reset("frz_rst");
    bus.req = 3'b010;
    bus.value0 = 12'h789;
    bus.value1 = 12'h321;
    release_reset();
    tick();
    check("frz_grant0", 32'(bus.grant), 32'h2);
    bus.req = 3'b011;
    tick();
    bus.freeze = 1'b1;
    bus.value1 = 12'h999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_grant", 32'(bus.grant), 32'h2);
      check("frz_digits", 32'(digits()), 32'h321);
    end
    bus.freeze = 1'b0;
    tick();
    check("frz_after_digits", 32'(digits()), 32'h999);
    check("frz_after_grant", 32'(bus.grant), 32'h2);
    tick();
    check("frz_last_grant", 32'(bus.grant), 32'h2);
    tick();
    check("frz_hand_grant", 32'(bus.grant), 32'h1);
    check("frz_hand_ack", 32'(bus.ack), 32'h1);
    check("frz_hand_digits", 32'(digits()), 32'h789);

    // All requests drop: back to IDLE; freeze blocks a new grant; then requester 2 wins.
    bus.req = 3'b000;
    tick();
    check("idle_grant", 32'(bus.grant), 32'h0);
    check("idle_digits", 32'(digits()), 32'h000);
    check("idle_ack", 32'(bus.ack), 32'h0);
    bus.freeze = 1'b1;
    bus.req = 3'b100;
    bus.value2 = 12'hFED;
    tick();
    check("idle_frz_grant", 32'(bus.grant), 32'h0);
    check("idle_frz_ack", 32'(bus.ack), 32'h0);
    bus.freeze = 1'b0;
    tick();
    check("idle_req2_ack", 32'(bus.ack), 32'h4);
    check("idle_req2_grant", 32'(bus.grant), 32'h4);
    check("idle_req2_digits", 32'(digits()), 32'hFED);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the 3-digit seven-segment display between three requesters (e.g. PC, register-file tap, status word), so that several debug sources can be viewed on the board without resynthesis. It sits directly in front of `SevenSeg` and drives its `digitL/digitM/digitR` inputs. It grants the display round-robin, holds each grant for a programmable dwell time, and returns a one-cycle acknowledge when a requester's value is first shown.

## Interface
- `DWELL`, default 2**22: minimum grant length in clk cycles when other requesters are waiting; legal range ≥ 2.
- `IDLE_VALUE`, default 12'h000: digits shown when no requester holds the display.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req`  in  3  per-requester display request, level-sensitive.
- `value0`, `value1`, `value2`  in  12 each  hex value per requester; [11:8] left digit, [7:4] middle, [3:0] right.
- `freeze`  in  1  when high, the display and arbitration are frozen.
- `grant`  out  3  one-hot owner of the display; 3'b000 in IDLE.
- `ack`  out  3  one-cycle one-hot pulse on the edge that grants a new owner.
- `digit_l`, `digit_m`, `digit_r`  out  4 each  digit values for the display driver.

## Operation
- All outputs are registered. The FSM has two states: IDLE and HOLD.
- State kept:
  - `last`, a 2-bit index of the previous winner.
  - `cnt`, the dwell down-counter, width clog2(DWELL).
- Round-robin search order is last+1, last+2, last+3 (mod 3). The first requester with `req` high wins.
- **IDLE**:
  - Outputs: `grant`=0, digits = IDLE_VALUE.
  - At an edge with any `req` high and `freeze` low, the FSM grants the winner:
    - `grant` takes the one-hot of the winner, and the matching `ack` bit goes high.
    - The digits load the winner's value and `cnt` loads DWELL-1.
    - `last` takes the winner index, and the FSM moves to HOLD.
- **HOLD** (owner k):
  - While `req[k]` is high, the digits follow `value_k` every cycle (live view).
  - `cnt` decrements each edge while it is non-zero.
  - Early release: if `req[k]` is low at an edge, the digits keep their last value and that edge behaves as expiry.
  - Expiry occurs at an edge where `cnt`==0 or `req[k]`==0. The round-robin search runs over `req`, starting after k and including k last:
    - **Winner j ≠ k:** grant j exactly as described for IDLE, including the `ack` pulse.
    - **Winner = k (only k requesting):** reload `cnt`=DWELL-1. No `ack`, and `grant` is unchanged.
    - **No requester:** go to IDLE. `grant`=0 and digits = IDLE_VALUE after this edge.
- **freeze**:
  - Any edge with `freeze` high leaves all registers unchanged in both states: no `cnt` decrement, no digit tracking, no grant, no `ack`.
  - `freeze` wins over expiry, early release and new requests.
- `ack` is never high for two consecutive cycles for the same requester unless a full re-grant occurs. At most one `ack` bit is high at a time.
- `value` inputs of non-owners are ignored.

## Timing
- Reset (asynchronous, immediate, including mid-HOLD):
  - State = IDLE, `grant`=0, `ack`=0.
  - Digits = IDLE_VALUE, `cnt`=0, `last`=2 (so requester 0 wins the first tie).
- Request latency: `req` high before edge N (IDLE, unfrozen) gives `grant`, `ack` and the digits valid after edge N. That is one cycle.
- `ack` is high for exactly the one cycle following the granting edge.
- Dwell with competitors waiting:
  - The owner holds for exactly DWELL cycles: granting edge N, hand-over at edge N+DWELL.
  - With `freeze` asserted for F cycles inside the dwell, the hand-over moves to N+DWELL+F.
- Live tracking: a `value_k` change before edge M appears on the digits after edge M.
- Simultaneous events:
  - Expiry and early release on the same edge: handled once, as expiry.
  - New request on the expiry edge: included in the search.
  - Release edge with no other `req`: the next state is IDLE.

## Test plan
Use DWELL=4 and IDLE_VALUE=12'h000 throughout.
- **Reset mid-HOLD:** `reset_n` low asynchronously between edges → `grant`=0, `ack`=0 and digits 0,0,0 immediately; after release, `req`=3'b001 → `ack`=3'b001 after one edge.
- **Tie after reset:** `req`=3'b111, value0=12'hABC, value1=12'h123, value2=12'h456 → grants in order 001 (digits A,B,C) then 010 then 100, each lasting 4 cycles, each with a single `ack` pulse.
- **Single requester:** `req`=3'b010 held for 20 cycles → `grant` stays 010, only one `ack`; value1 changing 12'h111→12'h222 is shown one cycle later.
- **Early release:** owner 0 drops `req` at cycle 2 of its dwell with `req[2]` high → grant hands to 100 on that edge with `ack`=100; digits = value2.
- **Freeze:** during owner 1's dwell, `freeze` is held high for 5 cycles with `req`=3'b011 → the digits and `grant` are unchanged; hand-over to 001 happens 4+5 cycles after the grant; changes to value1 are ignored while frozen.
- **Release to IDLE:** all `req` drop to 0 in HOLD → after the next edge `grant`=0 and digits 0,0,0; a later `req`=3'b100 → `ack`=100 after one edge.
